dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Shares the single data-memory port (dm) between the core load/store unit
//   (port C) and the program-loader/debug master (port L).
//   Sits between the requesters and dm and drives DMWr/DMCtrl/addr/DataWr
//   directly. dm reads are combinational and writes commit on posedge clk, so
//   a granted access completes in the cycle it is granted.
//   Adds fixed core priority with loader anti-starvation, loader bus lock, and
//   misalignment/illegal-ctrl trapping.
// PARAMETERS
//   STARVE_MAX  8   consecutive loader-wait cycles before loader is forced in (>=1)
//   CNT_W       4   width of starvation counter; must hold STARVE_MAX
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   async active-low reset
//   c_req      in   1   core access request
//   c_we       in   1   core store (1) / load (0)
//   c_ctrl     in   3   core DMCtrl encoding (000 B,001 H,010 W,100 BU,101 HU)
//   c_addr     in   32  core byte address
//   c_wdata    in   32  core store data
//   c_gnt      out  1   core access performed this cycle
//   c_stall    out  1   c_req & ~c_gnt; freezes core PC
//   c_rdata    out  32  load data (valid when c_gnt & ~c_we)
//   l_req, l_we, l_ctrl, l_addr, l_wdata   in  1/1/3/32/32   loader request, same meaning
//   l_lock     in   1   loader requests exclusive ownership after current grant
//   l_gnt      out  1   loader access performed this cycle
//   l_rdata    out  32  load data (valid when l_gnt & ~l_we)
//   dm_wr      out  1   to dm DMWr
//   dm_ctrl    out  3   to dm DMCtrl
//   dm_addr    out  32  to dm addr
//   dm_wdata   out  32  to dm DataWr
//   dm_rdata   in   32  from dm DataRd
//   err        out  1   sticky: misaligned or illegal access trapped
//   err_src    out  1   0 core, 1 loader (owner of first trapped access)
//   err_addr   out  32  address of first trapped access
//   err_clr    in   1   synchronous clear of err/err_src/err_addr
// BEHAVIOUR
//   Reset: state=ARB_CORE, starve_cnt=0, err=0, err_src=0, err_addr=0.
//     Combinational outputs follow inputs; with no requests all outputs are 0.
//   States: ARB_CORE, ARB_FORCE, ARB_LOCK (registered, 2 bits).
//   ARB_CORE: grant C if c_req, else L if l_req.
//     starve_cnt++ when l_req & ~l_gnt, else 0.
//     starve_cnt==STARVE_MAX-1 while L still waits -> ARB_FORCE next.
//     l_gnt & l_lock -> ARB_LOCK next.
//   ARB_FORCE: L granted if l_req, C stalled; starve_cnt:=0.
//     l_lock -> ARB_LOCK, else ARB_CORE. l_req dropped -> ARB_CORE, no grant.
//   ARB_LOCK: only L granted, C stalled every cycle.
//     Exit to ARB_CORE on the first cycle l_lock=0; that cycle is still L-owned.
//     starve_cnt held at 0.
//   Mux: dm_ctrl/dm_addr/dm_wdata come from granted port, else 0.
//     dm_wr = gnt_port.we & legal. c_rdata = l_rdata = dm_rdata when own port
//     granted & load & legal, else 0.
//   Legal: ctrl in {000,001,010,100,101} (writes: {000,001,010}).
//     H requires addr[0]==0; W requires addr[1:0]==0.
//   Illegal access: still "granted" (requester not hung), dm_wr forced 0,
//     rdata 0. err set next edge; err_src/err_addr captured only if err was 0.
//   err_clr and a new trap in the same cycle: trap wins (err stays 1, new capture).
//   Only one grant per cycle; c_gnt & l_gnt never both 1.
//   Async rst_n mid-lock or mid-force: immediately ARB_CORE, counter 0; any
//     write in that cycle is not issued (grant needs rst_n=1).
//   Latency: zero cycles for grant and read data; writes visible next cycle.
// TESTING
//   1. C and L both request continuously, STARVE_MAX=8 -> C granted 8 cycles,
//      L granted on cycle 9, C again on cycle 10; pattern repeats.
//   2. L SW 0x12345678 @0x10 with l_lock=1, then 3 more SW, lock drops on 4th
//      -> c_stall=1 for all 4 cycles; words 0x10..0x1C written; ARB_CORE after.
//   3. C LH @0x3 -> c_gnt=1, c_rdata=0, dm_wr=0; err=1, err_src=0,
//      err_addr=0x3 next cycle.
//   4. Error held, then L SW @0x6 -> err_addr stays 0x3. err_clr with no trap
//      -> err=0.
//   5. C SB 0xAB @0x20 then LBU @0x20 -> c_rdata=0x000000AB. LB -> 0xFFFFFFAB.
//   6. rst_n pulsed low during ARB_LOCK with l_we=1 -> no write; state ARB_CORE;
//      C granted on the first cycle after release.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the core load/store
// unit (port C) and the program-loader/debug master (port L).
//
// The data memory reads combinationally and commits writes on the rising
// clock edge, so a granted access completes in the cycle it is granted.
//
// Arbitration:
//   - ArbCore:  core has fixed priority; the loader gets the port only when the
//               core is idle. A loader that waits StarveMax consecutive cycles
//               is forced in for one cycle (ArbForce).
//   - ArbForce: loader owns the port for one cycle; core is stalled.
//   - ArbLock:  loader asked for exclusive ownership; core stalled until the
//               loader drops l_lock_i (that final cycle is still loader-owned).
//
// Accesses with an illegal ctrl code or a misaligned address are still granted
// so neither requester hangs, but the write strobe and read data are
// suppressed and a sticky error records the first offender.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   c_req_i/c_we_i/c_ctrl_i/
//   c_addr_i/c_wdata_i               core request (ctrl: B/H/W/BU/HU)
//   c_gnt_o, c_stall_o, c_rdata_o    core grant, stall, load data
//   l_req_i/l_we_i/l_ctrl_i/
//   l_addr_i/l_wdata_i/l_lock_i      loader request and bus-lock request
//   l_gnt_o, l_rdata_o               loader grant, load data
//   dm_wr_o/dm_ctrl_o/dm_addr_o/
//   dm_wdata_o, dm_rdata_i           data-memory port
//   err_o, err_src_o, err_addr_o     sticky trap flag, owner (1 = loader), addr
//   err_clr_i                        synchronous clear of the error record
module dm_arbiter #(
  parameter int unsigned StarveMax = 8,  // loader-wait cycles before forced grant (>= 1)
  parameter int unsigned CntW      = 4   // starvation counter width, must hold StarveMax
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // core port
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [2:0]  c_ctrl_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_gnt_o,
  output logic        c_stall_o,
  output logic [31:0] c_rdata_o,
  // loader port
  input  logic        l_req_i,
  input  logic        l_we_i,
  input  logic [2:0]  l_ctrl_i,
  input  logic [31:0] l_addr_i,
  input  logic [31:0] l_wdata_i,
  input  logic        l_lock_i,
  output logic        l_gnt_o,
  output logic [31:0] l_rdata_o,
  // data memory
  output logic        dm_wr_o,
  output logic [2:0]  dm_ctrl_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic [31:0] dm_rdata_i,
  // error record
  output logic        err_o,
  output logic        err_src_o,
  output logic [31:0] err_addr_o,
  input  logic        err_clr_i
);

  typedef enum logic [1:0] {
    ArbCore  = 2'd0,
    ArbForce = 2'd1,
    ArbLock  = 2'd2
  } arb_state_e;

  localparam logic [2:0] CtrlB  = 3'b000;
  localparam logic [2:0] CtrlH  = 3'b001;
  localparam logic [2:0] CtrlW  = 3'b010;
  localparam logic [2:0] CtrlBu = 3'b100;
  localparam logic [2:0] CtrlHu = 3'b101;

  localparam logic [CntW-1:0] StarveLast = CntW'(StarveMax - 1);

  // Unsigned loads have no store counterpart, so BU/HU writes are illegal.
  function automatic logic access_legal(input logic       we,
                                        input logic [2:0] ctrl,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      CtrlB:   ok = 1'b1;
      CtrlH:   ok = ~addr_lo[0];
      CtrlW:   ok = (addr_lo == 2'b00);
      CtrlBu:  ok = ~we;
      CtrlHu:  ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            err_q, err_d;
  logic            err_src_q, err_src_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic        c_sel, l_sel;
  logic        c_gnt, l_gnt, any_gnt;
  logic        g_we;
  logic [2:0]  g_ctrl;
  logic [31:0] g_addr, g_wdata;
  logic        g_legal;
  logic        trap;

  // Grant selection. Grants are qualified by rst_ni so nothing is issued to
  // the memory while reset is asserted, even mid-cycle.
  always_comb begin
    c_sel = 1'b0;
    l_sel = 1'b0;
    unique case (state_q)
      ArbCore: begin
        c_sel = c_req_i;
        l_sel = ~c_req_i & l_req_i;
      end
      ArbForce, ArbLock: begin
        l_sel = l_req_i;
      end
      default: ;
    endcase
    c_gnt   = c_sel & rst_ni;
    l_gnt   = l_sel & rst_ni;
    any_gnt = c_gnt | l_gnt;
  end

  // Request mux towards the memory.
  always_comb begin
    g_we    = 1'b0;
    g_ctrl  = 3'b000;
    g_addr  = 32'h0;
    g_wdata = 32'h0;
    if (c_gnt) begin
      g_we    = c_we_i;
      g_ctrl  = c_ctrl_i;
      g_addr  = c_addr_i;
      g_wdata = c_wdata_i;
    end else if (l_gnt) begin
      g_we    = l_we_i;
      g_ctrl  = l_ctrl_i;
      g_addr  = l_addr_i;
      g_wdata = l_wdata_i;
    end
    g_legal = access_legal(g_we, g_ctrl, g_addr[1:0]);
    trap    = any_gnt & ~g_legal;
  end

  always_comb begin
    c_gnt_o    = c_gnt;
    l_gnt_o    = l_gnt;
    c_stall_o  = c_req_i & ~c_gnt;
    dm_wr_o    = any_gnt & g_we & g_legal;
    dm_ctrl_o  = g_ctrl;
    dm_addr_o  = g_addr;
    dm_wdata_o = g_wdata;
    c_rdata_o  = (c_gnt & ~c_we_i & g_legal) ? dm_rdata_i : 32'h0;
    l_rdata_o  = (l_gnt & ~l_we_i & g_legal) ? dm_rdata_i : 32'h0;
    err_o      = err_q;
    err_src_o  = err_src_q;
    err_addr_o = err_addr_q;
  end

  // Arbitration state and starvation counter.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      ArbCore: begin
        if (l_gnt & l_lock_i) begin
          state_d      = ArbLock;
          starve_cnt_d = '0;
        end else if (l_req_i & ~l_gnt) begin
          if (starve_cnt_q == StarveLast) begin
            state_d      = ArbForce;
            starve_cnt_d = '0;
          end else begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      ArbForce: begin
        starve_cnt_d = '0;
        state_d      = (l_req_i & l_lock_i) ? ArbLock : ArbCore;
      end
      ArbLock: begin
        starve_cnt_d = '0;
        if (!l_lock_i) begin
          state_d = ArbCore;
        end
      end
      default: begin
        state_d      = ArbCore;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Error record. A trap in the same cycle as err_clr_i wins and recaptures.
  always_comb begin
    err_d      = err_q;
    err_src_d  = err_src_q;
    err_addr_d = err_addr_q;
    if (trap) begin
      err_d = 1'b1;
      if (!err_q || err_clr_i) begin
        err_src_d  = l_gnt;
        err_addr_d = g_addr;
      end
    end else if (err_clr_i) begin
      err_d      = 1'b0;
      err_src_d  = 1'b0;
      err_addr_d = 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ArbCore;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
      err_src_q    <= 1'b0;
      err_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      err_src_q    <= err_src_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a byte-addressed data-memory model
// (combinational read, write on rising edge). Memory byte i starts as i+1.
module tb_dm_arbiter;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk_i, rst_ni;
  logic        c_req_i, c_we_i;
  logic [2:0]  c_ctrl_i;
  logic [31:0] c_addr_i, c_wdata_i;
  logic        c_gnt_o, c_stall_o;
  logic [31:0] c_rdata_o;
  logic        l_req_i, l_we_i, l_lock_i;
  logic [2:0]  l_ctrl_i;
  logic [31:0] l_addr_i, l_wdata_i;
  logic        l_gnt_o;
  logic [31:0] l_rdata_o;
  logic        dm_wr_o;
  logic [2:0]  dm_ctrl_o;
  logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i;
  logic        err_o, err_src_o, err_clr_i;
  logic [31:0] err_addr_o;

  int n_vec = 0;
  int n_bad = 0;

  dm_arbiter #(.StarveMax(8), .CntW(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .c_req_i    (c_req_i),
    .c_we_i     (c_we_i),
    .c_ctrl_i   (c_ctrl_i),
    .c_addr_i   (c_addr_i),
    .c_wdata_i  (c_wdata_i),
    .c_gnt_o    (c_gnt_o),
    .c_stall_o  (c_stall_o),
    .c_rdata_o  (c_rdata_o),
    .l_req_i    (l_req_i),
    .l_we_i     (l_we_i),
    .l_ctrl_i   (l_ctrl_i),
    .l_addr_i   (l_addr_i),
    .l_wdata_i  (l_wdata_i),
    .l_lock_i   (l_lock_i),
    .l_gnt_o    (l_gnt_o),
    .l_rdata_o  (l_rdata_o),
    .dm_wr_o    (dm_wr_o),
    .dm_ctrl_o  (dm_ctrl_o),
    .dm_addr_o  (dm_addr_o),
    .dm_wdata_o (dm_wdata_o),
    .dm_rdata_i (dm_rdata_i),
    .err_o      (err_o),
    .err_src_o  (err_src_o),
    .err_addr_o (err_addr_o),
    .err_clr_i  (err_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Data-memory model.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  logic [7:0] ma, b0, b1, b2, b3, wa;

  always_comb begin
    ma = dm_addr_o[7:0];
    b0 = mem[ma];
    b1 = mem[ma + 8'd1];
    b2 = mem[ma + 8'd2];
    b3 = mem[ma + 8'd3];
    case (dm_ctrl_o)
      B:       dm_rdata_i = {{24{b0[7]}}, b0};
      H:       dm_rdata_i = {{16{b1[7]}}, b1, b0};
      W:       dm_rdata_i = {b3, b2, b1, b0};
      BU:      dm_rdata_i = {24'h0, b0};
      HU:      dm_rdata_i = {16'h0, b1, b0};
      default: dm_rdata_i = 32'h0;
    endcase
  end

  always @(posedge clk_i) begin
    wa = dm_addr_o[7:0];
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
      mem_ready <= 1'b1;
    end else if (dm_wr_o) begin
      mem[wa] <= dm_wdata_o[7:0];
      if (dm_ctrl_o == H || dm_ctrl_o == W) mem[wa + 8'd1] <= dm_wdata_o[15:8];
      if (dm_ctrl_o == W) begin
        mem[wa + 8'd2] <= dm_wdata_o[23:16];
        mem[wa + 8'd3] <= dm_wdata_o[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic c_drv(input logic req, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata);
    c_req_i = req; c_we_i = we; c_ctrl_i = ctrl; c_addr_i = addr; c_wdata_i = wdata;
  endtask

  task automatic l_drv(input logic req, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    l_req_i = req; l_we_i = we; l_ctrl_i = ctrl; l_addr_i = addr; l_wdata_i = wdata;
    l_lock_i = lock;
  endtask

  task automatic idle();
    c_drv(1'b0, 1'b0, B, 32'h0, 32'h0);
    l_drv(1'b0, 1'b0, B, 32'h0, 32'h0, 1'b0);
    err_clr_i = 1'b0;
  endtask

  initial begin
    logic        exp_l;
    logic [31:0] la, ld;
    rst_ni = 1'b0;
    idle();

    // Reset state; a request during reset is never granted.
    #12;
    check("rst_c_gnt", 32'(c_gnt_o), 32'h0);
    check("rst_l_gnt", 32'(l_gnt_o), 32'h0);
    check("rst_dm_wr", 32'(dm_wr_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_err_src", 32'(err_src_o), 32'h0);
    check("rst_err_addr", err_addr_o, 32'h0);
    c_drv(1'b1, 1'b1, W, 32'h0, 32'hFFFFFFFF);
    #1;
    check("rst_req_c_gnt", 32'(c_gnt_o), 32'h0);
    check("rst_req_dm_wr", 32'(dm_wr_o), 32'h0);
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // 1: both request; loader forced in every 9th cycle.
    c_drv(1'b1, 1'b0, W, 32'h0, 32'h0);
    l_drv(1'b1, 1'b0, W, 32'h4, 32'h0, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      exp_l = (i % 9 == 0);
      #2;
      check($sformatf("starve_c_gnt[%0d]", i), 32'(c_gnt_o), 32'(!exp_l));
      check($sformatf("starve_l_gnt[%0d]", i), 32'(l_gnt_o), 32'(exp_l));
      check($sformatf("starve_stall[%0d]", i), 32'(c_stall_o), 32'(exp_l));
      check($sformatf("starve_c_rd[%0d]", i), c_rdata_o, exp_l ? 32'h0 : 32'h04030201);
      check($sformatf("starve_l_rd[%0d]", i), l_rdata_o, exp_l ? 32'h08070605 : 32'h0);
      step();
    end
    idle();
    step();

    // 2: forced loader takes the lock and writes 4 words while core stalls.
    c_drv(1'b1, 1'b0, W, 32'h0, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      la = (i <= 9) ? 32'h10 : 32'h10 + 32'(4 * (i - 9));
      ld = (i <= 9) ? 32'h12345678 : 32'h11111111 * 32'(i - 8);
      l_drv(1'b1, 1'b1, W, la, ld, i < 12);
      exp_l = (i >= 9);
      #2;
      check($sformatf("lock_l_gnt[%0d]", i), 32'(l_gnt_o), 32'(exp_l));
      check($sformatf("lock_stall[%0d]", i), 32'(c_stall_o), 32'(exp_l));
      check($sformatf("lock_dm_wr[%0d]", i), 32'(dm_wr_o), 32'(exp_l));
      if (exp_l) check($sformatf("lock_dm_addr[%0d]", i), dm_addr_o, la);
      step();
    end
    l_drv(1'b0, 1'b0, B, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c_drv(1'b1, 1'b0, W, 32'h10 + 32'(4 * i), 32'h0);
      #2;
      check($sformatf("lock_rb_gnt[%0d]", i), 32'(c_gnt_o), 32'h1);
      check($sformatf("lock_rb[%0d]", i), c_rdata_o,
            (i == 0) ? 32'h12345678 : 32'h11111111 * 32'(i + 1));
      step();
    end

    // 3: misaligned core LH traps.
    c_drv(1'b1, 1'b0, H, 32'h3, 32'h0);
    #2;
    check("mis_c_gnt", 32'(c_gnt_o), 32'h1);
    check("mis_c_rdata", c_rdata_o, 32'h0);
    check("mis_dm_wr", 32'(dm_wr_o), 32'h0);
    check("mis_err_pre", 32'(err_o), 32'h0);
    step();
    idle();
    #2;
    check("mis_err", 32'(err_o), 32'h1);
    check("mis_err_src", 32'(err_src_o), 32'h0);
    check("mis_err_addr", err_addr_o, 32'h3);

    // 4: second trap does not overwrite; clear without trap.
    l_drv(1'b1, 1'b1, W, 32'h6, 32'h99999999, 1'b0);
    #2;
    check("t2_l_gnt", 32'(l_gnt_o), 32'h1);
    check("t2_dm_wr", 32'(dm_wr_o), 32'h0);
    step();
    idle();
    #2;
    check("t2_err", 32'(err_o), 32'h1);
    check("t2_err_src", 32'(err_src_o), 32'h0);
    check("t2_err_addr", err_addr_o, 32'h3);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    #2;
    check("clr_err", 32'(err_o), 32'h0);
    check("clr_err_addr", err_addr_o, 32'h0);

    // Trap coinciding with clear: trap wins and recaptures.
    c_drv(1'b1, 1'b0, W, 32'h2, 32'h0);
    step();
    idle();
    l_drv(1'b1, 1'b0, HU, 32'h5, 32'h0, 1'b0);
    err_clr_i = 1'b1;
    #2;
    check("tc_l_rdata", l_rdata_o, 32'h0);
    step();
    idle();
    #2;
    check("tc_err", 32'(err_o), 32'h1);
    check("tc_err_src", 32'(err_src_o), 32'h1);
    check("tc_err_addr", err_addr_o, 32'h5);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;

    // 5: byte store then sign/zero-extended loads.
    c_drv(1'b1, 1'b1, B, 32'h20, 32'h123456AB);
    #2;
    check("sb_dm_wr", 32'(dm_wr_o), 32'h1);
    step();
    c_drv(1'b1, 1'b0, BU, 32'h20, 32'h0);
    #2;
    check("lbu", c_rdata_o, 32'h000000AB);
    step();
    c_drv(1'b1, 1'b0, B, 32'h20, 32'h0);
    #2;
    check("lb", c_rdata_o, 32'hFFFFFFAB);
    step();
    c_drv(1'b1, 1'b0, HU, 32'h20, 32'h0);
    #2;
    check("lhu", c_rdata_o, 32'h000022AB);
    step();

    // Unsigned-width store code is illegal.
    c_drv(1'b1, 1'b1, BU, 32'h24, 32'h0);
    #2;
    check("ill_c_gnt", 32'(c_gnt_o), 32'h1);
    check("ill_dm_wr", 32'(dm_wr_o), 32'h0);
    step();
    idle();
    #2;
    check("ill_err_addr", err_addr_o, 32'h24);
    err_clr_i = 1'b1;
    step();
    idle();

    // 6: reset asserted mid-lock suppresses the pending write.
    l_drv(1'b1, 1'b1, W, 32'h40, 32'hDEADBEEF, 1'b1);
    #2;
    check("rl_first_wr", 32'(dm_wr_o), 32'h1);
    step();
    c_drv(1'b1, 1'b0, W, 32'h0, 32'h0);
    l_drv(1'b1, 1'b1, W, 32'h44, 32'hCAFEF00D, 1'b1);
    #2;
    check("rl_stall", 32'(c_stall_o), 32'h1);
    check("rl_l_gnt", 32'(l_gnt_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("rl_rst_l_gnt", 32'(l_gnt_o), 32'h0);
    check("rl_rst_dm_wr", 32'(dm_wr_o), 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rl_post_c_gnt", 32'(c_gnt_o), 32'h1);
    check("rl_post_l_gnt", 32'(l_gnt_o), 32'h0);
    step();
    l_drv(1'b0, 1'b0, B, 32'h0, 32'h0, 1'b0);
    c_drv(1'b1, 1'b0, W, 32'h44, 32'h0);
    #2;
    check("rl_no_write", c_rdata_o, 32'h48474645);
    step();
    c_drv(1'b1, 1'b0, W, 32'h40, 32'h0);
    #2;
    check("rl_first_word", c_rdata_o, 32'hDEADBEEF);
    step();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
